fifo_frame_engine: RTL and testbench
====================================

// Module: fifo_frame_engine
// PURPOSE
// - Hand-written stream engine between the host-to-FPGA 32-bit FIFO (read side) and the
//   FPGA-to-host 32-bit FIFO (write side). It pops framed requests from the input FIFO and
//   pushes framed responses into the output FIFO.
// - It presents the same ap_fifo-style port set as the HLS passthrough core, and is a drop-in
//   replacement for it on bus_clk.
// PARAMETERS
// - MAX_LEN  default 512   largest legal payload length N; a larger N is an error frame
// - OP_SUM   default 8'h01 opcode: reduce payload to wrapping sum + unsigned max
// - OP_PASS  default 8'h02 opcode: echo payload words unchanged
// PORTS
// - ap_clk           in   1   clock (bus_clk); the block has one clock
// - ap_rst           in   1   reset, synchronous, active-high (tie to !write_open && !read_open)
// - in_fifo_dout     in   32  input FIFO head word; FWFT, valid while in_fifo_empty_n=1
// - in_fifo_empty_n  in   1   input FIFO holds at least one word
// - in_fifo_read     out  1   pop the input head word this cycle
// - out_fifo_din     out  32  word to push
// - out_fifo_full_n  in   1   output FIFO can accept a word
// - out_fifo_write   out  1   push out_fifo_din this cycle
// - busy             out  1   a frame is in progress (state != IDLE)
// - frames_done      out  16  count of frames fully responded to; wraps at 0xFFFF->0
// BEHAVIOUR
// - Reset: in_fifo_read=0, out_fifo_write=0, out_fifo_din=0, busy=0, frames_done=0.
//   Accumulators cleared; state=IDLE.
// - Reset mid-frame aborts the frame at the next edge. Nothing resumes, and no response is
//   emitted for the aborted frame.
// - Frame layout: header word = {op[31:24], rsvd[23:16], N[15:0]}, followed by N payload words.
// - Response header = {op, status[23:16], N}. status bit0 = bad opcode; status bit1 = N>MAX_LEN.
// - Handshake rules:
//   - in_fifo_read is asserted only when in_fifo_empty_n=1.
//   - out_fifo_write is asserted only when out_fifo_full_n=1.
//   - Neither is ever asserted during reset.
// - States and transitions:
//   - IDLE: pop the header when empty_n=1. Latch op, N and status; clear sum and max.
//     Go to HDR_OUT.
//   - HDR_OUT: write the response header when full_n=1.
//     - status!=0 and N>0 -> DRAIN
//     - status!=0 and N=0 -> IDLE
//     - OP_PASS: N>0 -> PASS; N=0 -> IDLE
//     - OP_SUM: N>0 -> ACC; N=0 -> RES_SUM
//   - PASS: in_fifo_read = out_fifo_write = empty_n & full_n, with
//     out_fifo_din = in_fifo_dout (same cycle). Count the words; after word N go to IDLE.
//   - ACC: pop whenever empty_n=1 (independent of full_n). sum <= sum + word, modulo 2^32.
//     max <= unsigned max(max, word). After word N go to RES_SUM.
//   - RES_SUM: write sum, then go to RES_MAX.
//   - RES_MAX: write max, then go to IDLE.
//   - DRAIN: pop N words whenever empty_n=1, with no output, then go to IDLE.
// - N=0 with OP_SUM: response is header, 0, 0.
// - frames_done increments on the cycle the last response word of a frame is written.
// - Latency, assuming both FIFOs stay ready:
//   - header popped at cycle t -> response header written at t+1;
//   - last ACC word popped at t -> sum at t+1, max at t+2;
//   - PASS runs at 1 word/cycle;
//   - back-to-back frames: next header popped the cycle after IDLE is re-entered.
// - Stalls: full_n=0 holds the state and out_fifo_din stable. empty_n=0 inserts bubbles only;
//   it never drops or duplicates a word.
// - Words per frame: header + (PASS: N | SUM: 2 | error: 0) out; header + N in.
// - No word count is inferred from FIFO levels.
// TESTING
// - SUM {01_00_0003, 5, 0xFFFFFFFF, 7}
//   -> out 01000003, 0x0000000B (wrapped), 0xFFFFFFFF; frames_done=1.
// - PASS {02_00_0002, A, B} with out_fifo_full_n toggling every cycle
//   -> out 02000002, A, B in order; no duplicates; out_fifo_din stable while stalled.
// - Bad op {7F_00_0002, x, y}, then SUM {01_00_0000}
//   -> out 7F010002 then 01000000, 0, 0; x and y consumed; frames_done=2.
// - Length error: N=MAX_LEN+1 with OP_SUM
//   -> header status=02, all payload drained, next frame handled normally.
// - ap_rst pulsed after 2 of 4 PASS words
//   -> busy=0, outputs idle on the next cycle; frames_done=0; fresh frame after reset works.
// - Input starved (empty_n low 3 cycles mid-ACC)
//   -> sum/max identical to the unstalled run.

Source files
------------

// File: rtl/fifo_frame_engine.sv
// fifo_frame_engine
//   Stream engine between the host-to-FPGA 32-bit FIFO (read side, FWFT) and the
//   FPGA-to-host 32-bit FIFO (write side). Pops framed requests, pushes framed
//   responses. Drop-in replacement for the HLS passthrough core on bus_clk.
//
//   Frame in : {op[31:24], rsvd[23:16], N[15:0]} followed by N payload words
//   Frame out: {op, status[23:16], N} followed by
//              OP_PASS -> the N payload words, OP_SUM -> sum, max, error -> nothing
//   status bit0 = unknown opcode, bit1 = N > MAX_LEN
//
// Ports
//   ap_clk           in   clock (bus_clk)
//   ap_rst           in   synchronous active-high reset
//   in_fifo_dout     in   input FIFO head word, valid while in_fifo_empty_n=1
//   in_fifo_empty_n  in   input FIFO holds at least one word
//   in_fifo_read     out  pop the input head word this cycle
//   out_fifo_din     out  word to push
//   out_fifo_full_n  in   output FIFO can accept a word
//   out_fifo_write   out  push out_fifo_din this cycle
//   busy             out  a frame is in progress
//   frames_done      out  frames fully responded to, wraps at 0xFFFF
//
// state     | meaning
// ----------+-----------------------------------------------------------
// S_IDLE    | waiting for a header word; pops it and latches op/N/status
// S_HDR_OUT | writing the response header
// S_PASS    | echoing payload, one pop paired with one push
// S_ACC     | consuming payload into sum/max (output side not needed)
// S_RES_SUM | writing the wrapping sum
// S_RES_MAX | writing the unsigned max
// S_DRAIN   | discarding the payload of an error frame

module fifo_frame_engine #(
  parameter int         MAX_LEN = 512,
  parameter logic [7:0] OP_SUM  = 8'h01,
  parameter logic [7:0] OP_PASS = 8'h02
) (
  input  logic        ap_clk,
  input  logic        ap_rst,
  input  logic [31:0] in_fifo_dout,
  input  logic        in_fifo_empty_n,
  output logic        in_fifo_read,
  output logic [31:0] out_fifo_din,
  input  logic        out_fifo_full_n,
  output logic        out_fifo_write,
  output logic        busy,
  output logic [15:0] frames_done
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_HDR_OUT = 3'd1,
    S_PASS    = 3'd2,
    S_ACC     = 3'd3,
    S_RES_SUM = 3'd4,
    S_RES_MAX = 3'd5,
    S_DRAIN   = 3'd6
  } state_t;

  state_t      state;
  logic [7:0]  op_q;
  logic [1:0]  status_q;
  logic [15:0] len_q;
  logic [15:0] cnt_q;   // payload words still to consume, counts down to 1
  logic [31:0] sum_q;
  logic [31:0] max_q;
  logic [15:0] frames_q;

  logic        pop;
  logic        push;
  logic [7:0]  hdr_op;
  logic [15:0] hdr_len;
  logic        hdr_bad_op;
  logic        hdr_bad_len;
  logic        last_word;

  assign hdr_op      = in_fifo_dout[31:24];
  assign hdr_len     = in_fifo_dout[15:0];
  assign hdr_bad_op  = (hdr_op != OP_SUM) && (hdr_op != OP_PASS);
  assign hdr_bad_len = int'({16'd0, hdr_len}) > MAX_LEN;
  assign last_word   = (cnt_q == 16'd1);

  // Handshakes are combinational so that a pop/push is only ever offered while
  // the corresponding FIFO flag is true, and PASS can move a word per cycle.
  always_comb begin
    pop          = 1'b0;
    push         = 1'b0;
    out_fifo_din = 32'd0;
    if (!ap_rst) begin
      case (state)
        S_IDLE:    pop = in_fifo_empty_n;
        S_HDR_OUT: begin
          push         = out_fifo_full_n;
          out_fifo_din = {op_q, 6'd0, status_q, len_q};
        end
        S_PASS: begin
          pop          = in_fifo_empty_n & out_fifo_full_n;
          push         = in_fifo_empty_n & out_fifo_full_n;
          out_fifo_din = in_fifo_dout;
        end
        S_ACC:     pop = in_fifo_empty_n;
        S_DRAIN:   pop = in_fifo_empty_n;
        S_RES_SUM: begin
          push         = out_fifo_full_n;
          out_fifo_din = sum_q;
        end
        S_RES_MAX: begin
          push         = out_fifo_full_n;
          out_fifo_din = max_q;
        end
        default: ;
      endcase
    end
  end

  assign in_fifo_read   = pop;
  assign out_fifo_write = push;
  assign busy           = (state != S_IDLE);
  assign frames_done    = frames_q;

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      state    <= S_IDLE;
      op_q     <= 8'd0;
      status_q <= 2'd0;
      len_q    <= 16'd0;
      cnt_q    <= 16'd0;
      sum_q    <= 32'd0;
      max_q    <= 32'd0;
      frames_q <= 16'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (pop) begin
            op_q     <= hdr_op;
            len_q    <= hdr_len;
            cnt_q    <= hdr_len;
            status_q <= {hdr_bad_len, hdr_bad_op};
            sum_q    <= 32'd0;
            max_q    <= 32'd0;
            state    <= S_HDR_OUT;
          end
        end
        S_HDR_OUT: begin
          if (push) begin
            if (status_q != 2'd0) begin
              // Error frames are fully answered by the header alone.
              frames_q <= frames_q + 16'd1;
              state    <= (len_q != 16'd0) ? S_DRAIN : S_IDLE;
            end else if (op_q == OP_PASS) begin
              if (len_q != 16'd0) begin
                state <= S_PASS;
              end else begin
                frames_q <= frames_q + 16'd1;
                state    <= S_IDLE;
              end
            end else begin
              state <= (len_q != 16'd0) ? S_ACC : S_RES_SUM;
            end
          end
        end
        S_PASS: begin
          if (pop) begin
            cnt_q <= cnt_q - 16'd1;
            if (last_word) begin
              frames_q <= frames_q + 16'd1;
              state    <= S_IDLE;
            end
          end
        end
        S_ACC: begin
          if (pop) begin
            sum_q <= sum_q + in_fifo_dout;
            if (in_fifo_dout > max_q) max_q <= in_fifo_dout;
            cnt_q <= cnt_q - 16'd1;
            if (last_word) state <= S_RES_SUM;
          end
        end
        S_RES_SUM: begin
          if (push) state <= S_RES_MAX;
        end
        S_RES_MAX: begin
          if (push) begin
            frames_q <= frames_q + 16'd1;
            state    <= S_IDLE;
          end
        end
        S_DRAIN: begin
          if (pop) begin
            cnt_q <= cnt_q - 16'd1;
            if (last_word) state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_frame_engine.sv
// Directed bench for fifo_frame_engine. The two FIFOs are modelled as queues;
// inputs are driven on the falling edge and outputs sampled 1 ns later, and the
// pop/push seen at that point is applied as the rising edge would.

module tb_fifo_frame_engine;

  logic        ap_clk = 1'b0;
  logic        ap_rst;
  logic [31:0] in_fifo_dout;
  logic        in_fifo_empty_n;
  logic        in_fifo_read;
  logic [31:0] out_fifo_din;
  logic        out_fifo_full_n;
  logic        out_fifo_write;
  logic        busy;
  logic [15:0] frames_done;

  always #5 ap_clk = ~ap_clk;

  fifo_frame_engine dut (
    .ap_clk          (ap_clk),
    .ap_rst          (ap_rst),
    .in_fifo_dout    (in_fifo_dout),
    .in_fifo_empty_n (in_fifo_empty_n),
    .in_fifo_read    (in_fifo_read),
    .out_fifo_din    (out_fifo_din),
    .out_fifo_full_n (out_fifo_full_n),
    .out_fifo_write  (out_fifo_write),
    .busy            (busy),
    .frames_done     (frames_done)
  );

  int          checks   = 0;
  int          failures = 0;
  logic [31:0] inq[$];
  logic [31:0] outq[$];
  int          outc[$];
  int          popc[$];
  int          cyc      = 0;
  int          starve   = 0;
  bit          toggle_full = 0;
  bit          stab_en  = 0;
  bit          prev_stall = 0;
  logic [31:0] prev_din = 32'd0;
  int          viol     = 0;
  int          stab_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step(input bit rst = 1'b0);
    @(negedge ap_clk);
    cyc++;
    ap_rst          = rst;
    in_fifo_empty_n = (inq.size() > 0) && (starve == 0);
    in_fifo_dout    = (inq.size() > 0) ? inq[0] : 32'h0;
    out_fifo_full_n = toggle_full ? cyc[0] : 1'b1;
    if (starve > 0) starve--;
    #1;
    if (in_fifo_read) begin
      if (!in_fifo_empty_n || ap_rst) viol++;
      else begin
        void'(inq.pop_front());
        popc.push_back(cyc);
      end
    end
    if (out_fifo_write) begin
      if (!out_fifo_full_n || ap_rst) viol++;
      else begin
        outq.push_back(out_fifo_din);
        outc.push_back(cyc);
      end
    end
    if (stab_en && prev_stall && busy && (out_fifo_din != prev_din)) stab_err++;
    prev_stall = busy && !out_fifo_full_n;
    prev_din   = out_fifo_din;
  endtask

  task automatic clear_q();
    inq.delete();
    outq.delete();
    outc.delete();
    popc.delete();
  endtask

  task automatic run_frame(input string tag, input int n_out);
    int  budget;
    bit  done;
    budget = 0;
    done   = 0;
    while (!done && budget < 2000) begin
      step();
      budget++;
      done = (outq.size() >= n_out) && (inq.size() == 0) && !busy;
    end
    check({tag, "_done"}, 32'(done), 32'd1);
  endtask

  task automatic check_out(input string tag, input logic [31:0] exp[$]);
    check({tag, "_count"}, 32'(outq.size()), 32'(exp.size()));
    for (int i = 0; i < exp.size(); i++)
      check($sformatf("%s_w%0d", tag, i), outq[i], exp[i]);
  endtask

  logic [31:0] e[$];
  int          gap;

  initial begin
    ap_rst          = 1'b1;
    in_fifo_empty_n = 1'b0;
    in_fifo_dout    = 32'h0;
    out_fifo_full_n = 1'b1;

    // Reset with a word available and room downstream: nothing may move.
    inq.push_back(32'h01000000);
    step(1'b1);
    step(1'b1);
    check("rst_read",  32'(in_fifo_read),   32'd0);
    check("rst_write", 32'(out_fifo_write), 32'd0);
    check("rst_din",   out_fifo_din,        32'd0);
    check("rst_busy",  32'(busy),           32'd0);
    check("rst_frames", 32'(frames_done),   32'd0);
    check("rst_nopop", 32'(inq.size()),     32'd1);
    clear_q();

    // SUM with wraparound, plus latency checks.
    inq = '{32'h01000003, 32'h5, 32'hFFFFFFFF, 32'h7};
    run_frame("sum", 3);
    e = '{32'h01000003, 32'h0000000B, 32'hFFFFFFFF};
    check_out("sum", e);
    check("sum_frames", 32'(frames_done), 32'd1);
    check("sum_pops", 32'(popc.size()), 32'd4);
    check("lat_hdr", 32'(outc[0]), 32'(popc[0] + 1));
    check("lat_sum", 32'(outc[1]), 32'(popc[3] + 1));
    check("lat_max", 32'(outc[2]), 32'(popc[3] + 2));
    clear_q();

    // PASS with the output FIFO ready only every other cycle.
    toggle_full = 1;
    stab_en     = 1;
    inq = '{32'h02000002, 32'hAAAA0001, 32'hBBBB0002};
    run_frame("pass", 3);
    e = '{32'h02000002, 32'hAAAA0001, 32'hBBBB0002};
    check_out("pass", e);
    check("pass_stable", 32'(stab_err), 32'd0);
    check("pass_frames", 32'(frames_done), 32'd2);
    toggle_full = 0;
    stab_en     = 0;
    clear_q();

    // Bad opcode with payload, then an empty SUM.
    inq = '{32'h7F000002, 32'h11, 32'h22, 32'h01000000};
    run_frame("badop", 4);
    e = '{32'h7F010002, 32'h01000000, 32'h0, 32'h0};
    check_out("badop", e);
    check("badop_consumed", 32'(inq.size()), 32'd0);
    check("badop_frames", 32'(frames_done), 32'd4);
    clear_q();

    // N = MAX_LEN+1 is drained; the following frame is handled normally.
    inq.push_back(32'h01000201);
    for (int i = 0; i < 513; i++) inq.push_back(32'(i + 100));
    inq.push_back(32'h01000001);
    inq.push_back(32'h00000009);
    run_frame("len", 4);
    e = '{32'h01020201, 32'h01000001, 32'h9, 32'h9};
    check_out("len", e);
    check("len_frames", 32'(frames_done), 32'd6);
    check("len_pops", 32'(popc.size()), 32'd516);
    clear_q();

    // Input starved for three cycles in the middle of ACC.
    inq = '{32'h01000003, 32'h5, 32'hFFFFFFFF, 32'h7};
    for (int b = 0; b < 50 && inq.size() > 2; b++) step();
    starve = 3;
    run_frame("starve", 3);
    e = '{32'h01000003, 32'h0000000B, 32'hFFFFFFFF};
    check_out("starve", e);
    check("starve_frames", 32'(frames_done), 32'd7);
    clear_q();

    // Reset after two of four PASS words.
    inq = '{32'h02000004, 32'hC0DE0000, 32'hC0DE0001, 32'hC0DE0002, 32'hC0DE0003};
    for (int b = 0; b < 50 && outq.size() < 3; b++) step();
    check("prerst_words", 32'(outq.size()), 32'd3);
    gap = outc[2] - outc[1];
    check("pass_rate", 32'(gap), 32'd1);
    step(1'b1);
    check("midrst_read",  32'(in_fifo_read),   32'd0);
    check("midrst_write", 32'(out_fifo_write), 32'd0);
    check("midrst_din",   out_fifo_din,        32'd0);
    clear_q();
    step();
    check("postrst_busy",   32'(busy),           32'd0);
    check("postrst_frames", 32'(frames_done),    32'd0);
    check("postrst_write",  32'(out_fifo_write), 32'd0);
    check("postrst_out",    32'(outq.size()),    32'd0);
    inq = '{32'h02000001, 32'h12345678};
    run_frame("fresh", 2);
    e = '{32'h02000001, 32'h12345678};
    check_out("fresh", e);
    check("fresh_frames", 32'(frames_done), 32'd1);

    check("handshake_viol", 32'(viol), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
